// File: rtl/mips_defs_pkg.sv
// mips_defs: shared fetch-stage constants and next-PC target-select encoding
package mips_defs;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  typedef enum logic [1:0] {SEL_SEQ, SEL_JR, SEL_J, SEL_BR} tgt_sel_e;
  function automatic tgt_sel_e pick_sel(input logic jmp_reg, input logic jmp_imm, input logic jmp_branch);
    return jmp_reg ? SEL_JR : jmp_imm ? SEL_J : jmp_branch ? SEL_BR : SEL_SEQ;
  endfunction
endpackage

// File: rtl/perf_counter.sv
// perf_counter: wrapping event counter with enable and synchronous reset
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: IF stage owning the PC and IF/ID register, with redirect bubbles and perf counters
module fetch_redirect_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             load_use_stall,
  input  logic             branch_hazard,
  input  logic             ID_jmp_imm,
  input  logic             ID_jmp_reg,
  input  logic             ID_jmp_branch,
  input  logic [31:0]      ID_rs_value,
  input  logic [31:0]      IF_instr,
  output logic [31:0]      IF_pc,
  output logic [31:0]      ID_pc,
  output logic [31:0]      ID_instr,
  output logic             ID_valid,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_jump,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_stall
);
  logic [31:0] pc_d, pc_q, id_pc_d, id_pc_q, id_instr_d, id_instr_q, pc4, target;
  logic        id_valid_d, id_valid_q, stall, redirect, hold;
  tgt_sel_e    sel;
  always_comb begin
    stall      = load_use_stall | branch_hazard;
    sel        = pick_sel(ID_jmp_reg, ID_jmp_imm, ID_jmp_branch);
    redirect   = !stall && sel != SEL_SEQ;
    hold       = halt | stall;
    pc4        = id_pc_q + 32'd4;
    target     = sel == SEL_JR ? ID_rs_value :
                 sel == SEL_J  ? {pc4[31:28], id_instr_q[25:0], 2'b00} :
                                 pc4 + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
    pc_d       = hold ? pc_q : redirect ? target : pc_q + 32'd4;
    id_pc_d    = hold ? id_pc_q : redirect ? 32'h0 : pc_q;
    id_instr_d = hold ? id_instr_q : redirect ? NOP_INSTR : IF_instr;
    id_valid_d = hold ? id_valid_q : !redirect;
  end
  always_ff @(posedge clk) begin
    pc_q       <= rst ? RESET_PC : pc_d;
    id_pc_q    <= rst ? 32'h0 : id_pc_d;
    id_instr_q <= rst ? NOP_INSTR : id_instr_d;
    id_valid_q <= rst ? 1'b0 : id_valid_d;
  end
  assign IF_pc    = pc_q;
  assign ID_pc    = id_pc_q;
  assign ID_instr = id_instr_q;
  assign ID_valid = id_valid_q;
  perf_counter #(.W(CNT_W)) u_cycle (.clk(clk), .rst(rst), .en(!halt), .cnt(cnt_cycle));
  perf_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst(rst), .en(!halt && stall), .cnt(cnt_stall));
  perf_counter #(.W(CNT_W)) u_jump (.clk(clk), .rst(rst),
    .en(!halt && redirect && (sel == SEL_JR || sel == SEL_J)), .cnt(cnt_jump));
  perf_counter #(.W(CNT_W)) u_branch (.clk(clk), .rst(rst),
    .en(!halt && redirect && sel == SEL_BR), .cnt(cnt_branch));
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed checks of PC sequencing, redirects, stalls, halt, reset and wrap
module tb_fetch_redirect_unit;
  logic        clk = 0, rst, halt, load_use_stall, branch_hazard;
  logic        ID_jmp_imm, ID_jmp_reg, ID_jmp_branch;
  logic [31:0] ID_rs_value, IF_instr, IF_pc, ID_pc, ID_instr;
  logic        ID_valid;
  logic [31:0] cnt_cycle, cnt_jump, cnt_branch, cnt_stall;
  logic [31:0] s_pc, s_id_pc, s_id_instr;
  logic        s_valid;
  logic [1:0]  s_cycle, s_jump, s_branch, s_stall;
  int checks = 0, errors = 0;

  fetch_redirect_unit dut (
    .clk(clk), .rst(rst), .halt(halt), .load_use_stall(load_use_stall),
    .branch_hazard(branch_hazard), .ID_jmp_imm(ID_jmp_imm), .ID_jmp_reg(ID_jmp_reg),
    .ID_jmp_branch(ID_jmp_branch), .ID_rs_value(ID_rs_value), .IF_instr(IF_instr),
    .IF_pc(IF_pc), .ID_pc(ID_pc), .ID_instr(ID_instr), .ID_valid(ID_valid),
    .cnt_cycle(cnt_cycle), .cnt_jump(cnt_jump), .cnt_branch(cnt_branch), .cnt_stall(cnt_stall));

  fetch_redirect_unit #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .halt(halt), .load_use_stall(load_use_stall),
    .branch_hazard(branch_hazard), .ID_jmp_imm(ID_jmp_imm), .ID_jmp_reg(ID_jmp_reg),
    .ID_jmp_branch(ID_jmp_branch), .ID_rs_value(ID_rs_value), .IF_instr(IF_instr),
    .IF_pc(s_pc), .ID_pc(s_id_pc), .ID_instr(s_id_instr), .ID_valid(s_valid),
    .cnt_cycle(s_cycle), .cnt_jump(s_jump), .cnt_branch(s_branch), .cnt_stall(s_stall));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    {halt, load_use_stall, branch_hazard, ID_jmp_imm, ID_jmp_reg, ID_jmp_branch} = '0;
    ID_rs_value = 0;
    IF_instr = 32'h2001_0001;
    do_reset();
    check("rst_if_pc", IF_pc, 32'h3000);
    check("rst_id_pc", ID_pc, 0);
    check("rst_id_instr", ID_instr, 0);
    check("rst_id_valid", ID_valid, 0);
    check("rst_cnt_cycle", cnt_cycle, 0);
    check("rst_cnt_stall", cnt_stall, 0);

    step();
    check("t1_pc1", IF_pc, 32'h3004);
    check("t1_idpc1", ID_pc, 32'h3000);
    check("t1_idinstr1", ID_instr, 32'h2001_0001);
    check("t1_valid1", ID_valid, 1);
    step();
    check("t1_pc2", IF_pc, 32'h3008);
    check("t1_idpc2", ID_pc, 32'h3004);
    step();
    check("t1_pc3", IF_pc, 32'h300C);
    check("t1_cycle3", cnt_cycle, 3);
    check("t1_small_cycle3", s_cycle, 3);
    step();
    check("t1_cycle4", cnt_cycle, 4);
    check("wrap_small_cycle", s_cycle, 0);

    do_reset();
    step();
    IF_instr = 32'h0800_0C10;
    step();
    check("t2_idpc", ID_pc, 32'h3004);
    ID_jmp_imm = 1;
    IF_instr = 32'h2001_0001;
    step();
    ID_jmp_imm = 0;
    check("t2_target", IF_pc, 32'h3040);
    check("t2_bubble_valid", ID_valid, 0);
    check("t2_bubble_instr", ID_instr, 0);
    check("t2_bubble_pc", ID_pc, 0);
    check("t2_cnt_jump", cnt_jump, 1);
    step();
    check("t2_after_pc", IF_pc, 32'h3044);
    check("t2_after_idpc", ID_pc, 32'h3040);
    check("t2_after_valid", ID_valid, 1);

    do_reset();
    repeat (4) step();
    IF_instr = 32'h1000_FFFE;
    step();
    IF_instr = 32'h2001_0001;
    check("t3_idpc", ID_pc, 32'h3010);
    check("t3_pc", IF_pc, 32'h3014);
    branch_hazard = 1;
    ID_jmp_branch = 1;
    step();
    check("t3_hold1_pc", IF_pc, 32'h3014);
    check("t3_hold1_idpc", ID_pc, 32'h3010);
    check("t3_hold1_branch", cnt_branch, 0);
    step();
    check("t3_hold2_pc", IF_pc, 32'h3014);
    check("t3_cnt_stall", cnt_stall, 2);
    branch_hazard = 0;
    step();
    ID_jmp_branch = 0;
    check("t3_target", IF_pc, 32'h300C);
    check("t3_cnt_branch", cnt_branch, 1);
    check("t3_stall_kept", cnt_stall, 2);
    check("t3_bubble", ID_valid, 0);
    check("t3_cycle", cnt_cycle, 8);

    ID_rs_value = 32'h0000_4000;
    ID_jmp_reg = 1;
    ID_jmp_branch = 1;
    step();
    ID_jmp_reg = 0;
    ID_jmp_branch = 0;
    check("t4_target", IF_pc, 32'h4000);
    check("t4_cnt_jump", cnt_jump, 1);
    check("t4_cnt_branch", cnt_branch, 1);

    step();
    check("t5_pre_pc", IF_pc, 32'h4004);
    check("t5_pre_cycle", cnt_cycle, 10);
    halt = 1;
    load_use_stall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_pc", IF_pc, 32'h4004);
      check("t5_idpc", ID_pc, 32'h4000);
      check("t5_valid", ID_valid, 1);
      check("t5_cycle", cnt_cycle, 10);
      check("t5_stall", cnt_stall, 2);
    end
    halt = 0;
    load_use_stall = 0;

    ID_jmp_imm = 1;
    rst = 1;
    step();
    rst = 0;
    ID_jmp_imm = 0;
    check("t6_pc", IF_pc, 32'h3000);
    check("t6_valid", ID_valid, 0);
    check("t6_jump", cnt_jump, 0);
    check("t6_cycle", cnt_cycle, 0);
    step();
    check("t6_next_pc", IF_pc, 32'h3004);
    check("t6_next_jump", cnt_jump, 0);

    ID_rs_value = 32'hFFFF_FFFC;
    ID_jmp_reg = 1;
    step();
    ID_jmp_reg = 0;
    check("pcwrap_top", IF_pc, 32'hFFFF_FFFC);
    step();
    check("pcwrap_zero", IF_pc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
